// File: rtl/pci_master_req_if.sv
// PCI initiator bus signals between the bus-ownership controller and the
// bus/arbiter side.
//   master modport: controller side. It drives REQn, FRAMEn_out, IRDYn_out,
//                   frame_oe and irdy_oe, and samples GNTn, FRAMEn_in,
//                   IRDYn_in, TRDYn and STOPn.
//   slave modport : arbiter/bus side, with the opposite directions.
// All bus signals are active-low.
interface pci_master_req_if;
  logic REQn;
  logic GNTn;
  logic FRAMEn_in;
  logic IRDYn_in;
  logic TRDYn;
  logic STOPn;
  logic FRAMEn_out;
  logic IRDYn_out;
  logic frame_oe;
  logic irdy_oe;

  modport master (
    output REQn, FRAMEn_out, IRDYn_out, frame_oe, irdy_oe,
    input  GNTn, FRAMEn_in, IRDYn_in, TRDYn, STOPn
  );

  modport slave (
    input  REQn, FRAMEn_out, IRDYn_out, frame_oe, irdy_oe,
    output GNTn, FRAMEn_in, IRDYn_in, TRDYn, STOPn
  );
endinterface

// File: rtl/pci_master_req.sv
// Per-agent PCI initiator bus-ownership controller.
// It turns a local burst request into a REQn/GNTn arbitration, waits for an
// idle bus, and then drives the FRAME#/IRDY# address and data phases. It
// counts completed data phases and ends the tenure early on latency-timer
// expiry or on a target STOP#. Any unfinished remainder is resumed by
// arbitrating again.
// Ports:
//   clk, reset  rising-edge clock and synchronous active-high reset
//   start       1-cycle request pulse, ignored while busy
//   burst_len   number of data phases, latched on start (0 means 1)
//   bus         PCI signals (master modport of pci_master_req_if)
//   data_ack    1-cycle pulse per completed data phase
//   busy        high from the cycle after start until the burst finishes
//   done        1-cycle pulse when the whole burst has completed
// Every output comes straight from a flop. The comb block computes the next
// value of the complete register set.
module pci_master_req #(
  parameter int CNT_W     = 4,
  parameter int LAT_TIMER = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  pci_master_req_if.master bus,
  output logic             data_ack,
  output logic             busy,
  output logic             done
);
  localparam int LAT_W = $clog2(LAT_TIMER + 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] rem;
    logic [LAT_W-1:0] lat;
    logic             reqn;
    logic             framen;
    logic             irdyn;
    logic             frame_oe;
    logic             irdy_oe;
    logic             data_ack;
    logic             busy;
    logic             done;
  } regs_t;

  regs_t            r, r_nxt;
  logic [LAT_W-1:0] lat_dec;
  logic [CNT_W-1:0] rem_dec;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r.state    <= IDLE;
      r.rem      <= '0;
      r.lat      <= '0;
      r.reqn     <= 1'b1;
      r.framen   <= 1'b1;
      r.irdyn    <= 1'b1;
      r.frame_oe <= 1'b0;
      r.irdy_oe  <= 1'b0;
      r.data_ack <= 1'b0;
      r.busy     <= 1'b0;
      r.done     <= 1'b0;
    end else begin
      r <= r_nxt;
    end
  end

  always_comb begin
    r_nxt          = r;
    r_nxt.data_ack = 1'b0;
    r_nxt.done     = 1'b0;
    // The latency counter runs from the address phase and stays at zero
    // once it gets there. Expiry is judged on the post-decrement value, so
    // FRAME# is held for exactly LAT_TIMER cycles before GNTn loss can end
    // the tenure.
    lat_dec = (r.lat == '0) ? '0 : r.lat - LAT_W'(1);
    // IRDY# is only ever low in DATA, so xfer cannot fire in any other state.
    xfer    = !r.irdyn && !bus.TRDYn;
    rem_dec = xfer ? r.rem - CNT_W'(1) : r.rem;

    case (r.state)
      IDLE: if (start) begin
        r_nxt.state = REQ;
        r_nxt.rem   = (burst_len == '0) ? CNT_W'(1) : burst_len;
        r_nxt.busy  = 1'b1;
        r_nxt.reqn  = 1'b0;
      end
      REQ: if (!bus.GNTn && bus.FRAMEn_in && bus.IRDYn_in) begin
        r_nxt.state    = ADDR;
        r_nxt.framen   = 1'b0;
        r_nxt.frame_oe = 1'b1;
        r_nxt.irdy_oe  = 1'b1;
        r_nxt.lat      = LAT_W'(LAT_TIMER);
      end
      ADDR: begin
        r_nxt.state = DATA;
        r_nxt.irdyn = 1'b0;
        r_nxt.lat   = lat_dec;
        // For a single phase, the first data phase is already the last one.
        if (r.rem == CNT_W'(1)) begin
          r_nxt.framen = 1'b1;
          r_nxt.reqn   = 1'b1;
        end
      end
      DATA: begin
        r_nxt.lat      = lat_dec;
        r_nxt.rem      = rem_dec;
        r_nxt.data_ack = xfer;
        if (r.framen) begin
          // Final phase: it ends on TRDY# (with data) or on STOP#.
          if (!bus.TRDYn || !bus.STOPn) begin
            r_nxt.state    = TURN;
            r_nxt.irdyn    = 1'b1;
            r_nxt.frame_oe = 1'b0;
          end
        end else if (rem_dec == CNT_W'(1) || !bus.STOPn ||
                     (lat_dec == '0 && bus.GNTn)) begin
          r_nxt.framen = 1'b1;
          r_nxt.reqn   = 1'b1;
        end
      end
      TURN: begin
        r_nxt.irdy_oe = 1'b0;
        if (r.rem == '0) begin
          r_nxt.state = IDLE;
          r_nxt.busy  = 1'b0;
          r_nxt.done  = 1'b1;
        end else begin
          r_nxt.state = REQ;
          r_nxt.reqn  = 1'b0;
        end
      end
      default: r_nxt.state = IDLE;
    endcase
  end

  assign bus.REQn       = r.reqn;
  assign bus.FRAMEn_out = r.framen;
  assign bus.IRDYn_out  = r.irdyn;
  assign bus.frame_oe   = r.frame_oe;
  assign bus.irdy_oe    = r.irdy_oe;
  assign data_ack       = r.data_ack;
  assign busy           = r.busy;
  assign done           = r.done;
endmodule
